// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared pipeline types for the scoreboard hazard unit:
//                issue-class encodings, hazard FSM states, latency defaults.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    localparam int LOAD_LAT_DEF = 1;
    localparam int MUL_LAT_DEF  = 3;
    localparam int CNT_W_DEF    = 3;

    typedef enum logic [1:0] {
        CLS_ALU  = 2'b00,
        CLS_LOAD = 2'b01,
        CLS_MUL  = 2'b10,
        CLS_RSVD = 2'b11
    } issue_class_e;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } sb_state_e;

endpackage
`default_nettype wire

// File: rtl/scoreboard_hazard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_hazard_unit_if
//  Description : ID-stage issue/operand/fence bundle between the pipeline
//                control (master) and the scoreboard hazard unit (slave).
//                SCOREBOARD_STATS_EN adds the stall/fence cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
interface scoreboard_hazard_unit_if;

    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_regWrite;
    logic [1:0]  issue_class;
    logic [4:0]  rs1_ID;
    logic [4:0]  rs2_ID;
    logic        use_rs1;
    logic        use_rs2;
    logic        flush_ID;
    logic        fence_req;
    logic        stall_ID;
    logic        fence_done;
    logic [31:0] busy_vec;
`ifdef SCOREBOARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] fence_cycles;

    modport master (
        output issue_valid, issue_rd, issue_regWrite, issue_class,
        output rs1_ID, rs2_ID, use_rs1, use_rs2, flush_ID, fence_req,
        input  stall_ID, fence_done, busy_vec, stall_cycles, fence_cycles
    );

    modport slave (
        input  issue_valid, issue_rd, issue_regWrite, issue_class,
        input  rs1_ID, rs2_ID, use_rs1, use_rs2, flush_ID, fence_req,
        output stall_ID, fence_done, busy_vec, stall_cycles, fence_cycles
    );
`else
    modport master (
        output issue_valid, issue_rd, issue_regWrite, issue_class,
        output rs1_ID, rs2_ID, use_rs1, use_rs2, flush_ID, fence_req,
        input  stall_ID, fence_done, busy_vec
    );

    modport slave (
        input  issue_valid, issue_rd, issue_regWrite, issue_class,
        input  rs1_ID, rs2_ID, use_rs1, use_rs2, flush_ID, fence_req,
        output stall_ID, fence_done, busy_vec
    );
`endif

endinterface
`default_nettype wire

// File: rtl/sb_entry.sv
`default_nettype none
// ============================================================================
//  Module      : sb_entry
//  Description : One register's in-flight writer countdown. Decrements to
//                zero every cycle; a new mark only ever lengthens the wait,
//                so an older longer-latency writer is never shortened (WAW).
//  Revision    : 1.0 - initial release
// ============================================================================
module sb_entry #(
    parameter int CNT_W = 3
) (
    input  wire logic             CLK,
    input  wire logic             RSTn,
    input  wire logic             mark,
    input  wire logic [CNT_W-1:0] lat,
    output      logic [CNT_W-1:0] count,
    output      logic             busy
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_dec;

    assign w_dec = (r_count != '0) ? (r_count - CNT_W'(1)) : '0;

    // Countdown register: saturating decrement, max-merge on a new mark
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_count <= '0;
        end else if (mark && (lat > w_dec)) begin
            r_count <= lat;
        end else begin
            r_count <= w_dec;
        end
    end

    assign count = r_count;
    assign busy  = (r_count != '0);

endmodule
`default_nettype wire

// File: rtl/scoreboard_hazard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : scoreboard_hazard_unit
//  Description : Tracks in-flight multi-cycle writers (loads, multiplies) per
//                destination register, stalls ID while a source operand is
//                not yet reachable by forwarding, and drains the scoreboard
//                for FENCE. Optional macro SCOREBOARD_STATS_EN adds the
//                stall_cycles / fence_cycles saturating counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module scoreboard_hazard_unit
    import pipe_pkg::*;
#(
    parameter int LOAD_LAT = LOAD_LAT_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input wire logic                 CLK,
    input wire logic                 RSTn,
    scoreboard_hazard_unit_if.slave  bus
);

    sb_state_e             r_state;
    sb_state_e             w_state_nxt;
    logic                  r_fence_done;
    logic                  w_fence_done_nxt;
    logic                  w_fence_done;
    logic                  w_stall;
    logic                  w_hazard;
    logic                  w_any_busy;
    logic                  w_drain_done;
    logic                  w_issue_eff;
    logic                  w_mark_any;
    logic [CNT_W-1:0]      w_lat;
    logic [31:0]           w_busy;
    logic [31:0][CNT_W-1:0] w_count;

    // Register x0 is never tracked
    assign w_busy[0]  = 1'b0;
    assign w_count[0] = '0;

    // Latency of the issuing instruction; reserved class behaves as ALU
    always_comb begin
        w_lat = '0;
        case (issue_class_e'(bus.issue_class))
            CLS_LOAD: w_lat = CNT_W'(LOAD_LAT);
            CLS_MUL:  w_lat = CNT_W'(MUL_LAT);
            default:  w_lat = '0;
        endcase
    end

    assign w_issue_eff = bus.issue_valid && !w_stall && !bus.flush_ID;
    assign w_mark_any  = w_issue_eff && bus.issue_regWrite &&
                         (bus.issue_rd != 5'd0) && (w_lat != '0);

    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_entry
            sb_entry #(
                .CNT_W (CNT_W)
            ) u_entry (
                .CLK   (CLK),
                .RSTn  (RSTn),
                .mark  (w_mark_any && (bus.issue_rd == 5'(gi))),
                .lat   (w_lat),
                .count (w_count[gi]),
                .busy  (w_busy[gi])
            );
        end
    endgenerate

    assign w_any_busy = |w_busy;

    assign w_hazard = (bus.use_rs1 && (bus.rs1_ID != 5'd0) && w_busy[bus.rs1_ID]) ||
                      (bus.use_rs2 && (bus.rs2_ID != 5'd0) && w_busy[bus.rs2_ID]);

    // Drain completes when every count is zero after this cycle's decrement
    always_comb begin
        w_drain_done = 1'b1;
        for (int i = 1; i < 32; i++) begin
            if (w_count[i] > CNT_W'(1)) begin
                w_drain_done = 1'b0;
            end
        end
    end

    // FSM state and registered drain-complete pulse
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state      <= RUN;
            r_fence_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_fence_done <= w_fence_done_nxt;
        end
    end

    // FSM next state, stall and fence completion
    always_comb begin
        w_state_nxt      = r_state;
        w_stall          = 1'b0;
        w_fence_done_nxt = 1'b0;
        w_fence_done     = r_fence_done;
        case (r_state)
            RUN: begin
                w_stall = w_hazard;
                if (bus.fence_req && !bus.flush_ID) begin
                    if (w_any_busy) begin
                        w_state_nxt = DRAIN;
                    end else begin
                        w_fence_done = 1'b1;
                    end
                end
            end
            DRAIN: begin
                w_stall = 1'b1;
                if (bus.flush_ID) begin
                    w_state_nxt = RUN;
                end else if (w_drain_done) begin
                    w_state_nxt      = RUN;
                    w_fence_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = RUN;
            end
        endcase
        // A squashed ID instruction never needs holding
        if (bus.flush_ID) begin
            w_stall = 1'b0;
        end
    end

    assign bus.stall_ID   = w_stall;
    assign bus.fence_done = w_fence_done;
    assign bus.busy_vec   = w_busy;

`ifdef SCOREBOARD_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_fence_cycles;

    // Saturating counters of RUN stall cycles and DRAIN cycles
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_stall_cycles <= '0;
            r_fence_cycles <= '0;
        end else begin
            if ((r_state == RUN) && w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
            if ((r_state == DRAIN) && (r_fence_cycles != '1)) begin
                r_fence_cycles <= r_fence_cycles + 32'd1;
            end
        end
    end

    assign bus.stall_cycles = r_stall_cycles;
    assign bus.fence_cycles = r_fence_cycles;
`endif

endmodule
`default_nettype wire
